// File: rtl/multi_alarm_cont.sv
// Purpose: N-channel alarm controller. Matches stored alarm times on each second tick, queues the hits
//          and rings one channel at a time, with snooze, ring auto-stop timeout and a piezo beep gate.
// Latency: a hit on a SEC_TICK cycle rings from the next cycle; writes take effect on the next cycle.
// Backpressure: none. Coincident hits are held in a pending mask until the ring slot is free.
// Ports: CLK/RESETN (sync, active-high reset); CUR_TIME/SEC_TICK from the time base;
//        WR_* alarm programming with WR_ERR reject pulse; STOP/SNOOZE key pulses;
//        RD_IDX -> RD_TIME/RD_ON combinational read-back; RINGING/RING_IDX/SNZ_ACTIVE/PIEZO_EN status.
module multi_alarm_cont #(
  parameter int NUM_ALARMS = 4,
  parameter int IDX_W      = 2,
  parameter int SNOOZE_MIN = 5,
  parameter int RING_SECS  = 60
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic [16:0]      CUR_TIME,
  input  logic             SEC_TICK,
  input  logic             WR_EN,
  input  logic [IDX_W-1:0] WR_IDX,
  input  logic [16:0]      WR_TIME,
  input  logic             WR_ON,
  input  logic             STOP,
  input  logic             SNOOZE,
  input  logic [IDX_W-1:0] RD_IDX,
  output logic [16:0]      RD_TIME,
  output logic             RD_ON,
  output logic             WR_ERR,
  output logic             RINGING,
  output logic [IDX_W-1:0] RING_IDX,
  output logic             SNZ_ACTIVE,
  output logic             PIEZO_EN
);

  typedef struct packed {
    logic [4:0] hour;
    logic [5:0] min;
    logic [5:0] sec;
  } hms_t;

  typedef enum logic {ST_IDLE, ST_RING} state_t;

  hms_t                  alarm_time [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] en;
  logic [NUM_ALARMS-1:0] pend, pend_n;
  logic                  snz_valid, snz_valid_n;
  hms_t                  snz_time, snz_time_n;
  logic [IDX_W-1:0]      snz_idx, snz_idx_n;
  state_t                state, state_n;
  logic [IDX_W-1:0]      ring_idx, ring_idx_n;
  logic [7:0]            rc, rc_n;
  logic                  gate, gate_n;
  logic                  wr_err, wr_err_n;

  hms_t                  cur, wr_t, snz_calc;
  logic [NUM_ALARMS-1:0] hit, pend_all;
  logic [IDX_W-1:0]      first_idx;
  logic                  wr_ok;
  logic [6:0]            min_sum;

  assign cur  = hms_t'(CUR_TIME);
  assign wr_t = hms_t'(WR_TIME);

  assign wr_ok = WR_EN && (int'(WR_IDX) < NUM_ALARMS) &&
                 (wr_t.hour <= 5'd23) && (wr_t.min <= 6'd59) && (wr_t.sec <= 6'd59);

  // Snooze target: current time plus SNOOZE_MIN minutes, seconds kept, wrapping at midnight.
  always_comb begin
    snz_calc = cur;
    min_sum  = {1'b0, cur.min} + 7'(SNOOZE_MIN);
    if (min_sum >= 7'd60) begin
      snz_calc.min  = 6'(min_sum - 7'd60);
      snz_calc.hour = (cur.hour >= 5'd23) ? 5'd0 : cur.hour + 5'd1;
    end else begin
      snz_calc.min = min_sum[5:0];
    end
  end

  // Hits are evaluated against the pre-write alarm table.
  always_comb begin
    hit         = '0;
    snz_valid_n = snz_valid;
    snz_time_n  = snz_time;
    snz_idx_n   = snz_idx;
    if (SEC_TICK) begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        hit[i] = en[i] && (alarm_time[i] == cur);
      end
      // A due snooze rings its channel even if that channel is disabled.
      if (snz_valid && (snz_time == cur)) begin
        hit[snz_idx] = 1'b1;
        snz_valid_n  = 1'b0;
      end
    end
    pend_all = pend | hit;

    first_idx = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (pend_all[i]) first_idx = IDX_W'(i);
    end

    state_n    = state;
    ring_idx_n = ring_idx;
    rc_n       = rc;
    gate_n     = gate;
    pend_n     = pend_all;

    case (state)
      ST_IDLE: begin
        if (|pend_all) begin
          state_n           = ST_RING;
          ring_idx_n        = first_idx;
          pend_n[first_idx] = 1'b0;
          rc_n              = 8'd0;
          gate_n            = 1'b1;
        end
      end
      ST_RING: begin
        if (STOP) begin
          state_n = ST_IDLE;
        end else if (SNOOZE) begin
          snz_time_n  = snz_calc;
          snz_idx_n   = ring_idx;
          snz_valid_n = 1'b1;
          state_n     = ST_IDLE;
        end else if (SEC_TICK) begin
          rc_n   = rc + 8'd1;
          gate_n = ~gate;
          if (rc_n == 8'(RING_SECS)) state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    // Disabling a channel drops its queued hit and any snooze aimed at it, but not a live ring.
    if (wr_ok && !WR_ON) begin
      pend_n[WR_IDX] = 1'b0;
      if (snz_idx_n == WR_IDX) snz_valid_n = 1'b0;
    end

    wr_err_n = WR_EN && !wr_ok;
  end

  always_ff @(posedge CLK) begin
    if (RESETN) begin
      for (int i = 0; i < NUM_ALARMS; i++) alarm_time[i] <= '0;
      en        <= '0;
      pend      <= '0;
      snz_valid <= 1'b0;
      snz_time  <= '0;
      snz_idx   <= '0;
      state     <= ST_IDLE;
      ring_idx  <= '0;
      rc        <= 8'd0;
      gate      <= 1'b0;
      wr_err    <= 1'b0;
    end else begin
      if (wr_ok) begin
        alarm_time[WR_IDX] <= wr_t;
        en[WR_IDX]         <= WR_ON;
      end
      pend      <= pend_n;
      snz_valid <= snz_valid_n;
      snz_time  <= snz_time_n;
      snz_idx   <= snz_idx_n;
      state     <= state_n;
      ring_idx  <= ring_idx_n;
      rc        <= rc_n;
      gate      <= gate_n;
      wr_err    <= wr_err_n;
    end
  end

  assign RD_TIME    = (int'(RD_IDX) < NUM_ALARMS) ? alarm_time[RD_IDX] : '0;
  assign RD_ON      = (int'(RD_IDX) < NUM_ALARMS) ? en[RD_IDX] : 1'b0;
  assign WR_ERR     = wr_err;
  assign RINGING    = (state == ST_RING);
  assign RING_IDX   = ring_idx;
  assign SNZ_ACTIVE = snz_valid;
  assign PIEZO_EN   = RINGING & gate;

endmodule

// File: tb/tb_multi_alarm_cont.sv
module tb_multi_alarm_cont;

  localparam int NA = 3;
  localparam int SN = 5;
  localparam int RS = 60;

  logic        CLK;
  logic        RESETN;
  logic [16:0] CUR_TIME;
  logic        SEC_TICK;
  logic        WR_EN;
  logic [1:0]  WR_IDX;
  logic [16:0] WR_TIME;
  logic        WR_ON;
  logic        STOP;
  logic        SNOOZE;
  logic [1:0]  RD_IDX;
  logic [16:0] RD_TIME;
  logic        RD_ON;
  logic        WR_ERR;
  logic        RINGING;
  logic [1:0]  RING_IDX;
  logic        SNZ_ACTIVE;
  logic        PIEZO_EN;

  int cur_h, cur_m, cur_s;
  int wr_h, wr_m, wr_s;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state, times kept as seconds of the day.
  int m_t [NA];
  bit m_en [NA];
  bit m_pend [NA];
  bit m_snz_v;
  int m_snz_t;
  int m_snz_i;
  bit m_ring;
  int m_ridx;
  int m_secs;
  bit m_err;

  int pool [6] = '{23400, 25200, 23700, 25500, 86290, 190};

  function automatic logic [16:0] pk(int h, int m, int s);
    return {5'(h), 6'(m), 6'(s)};
  endfunction

  assign CUR_TIME = pk(cur_h, cur_m, cur_s);
  assign WR_TIME  = pk(wr_h, wr_m, wr_s);

  multi_alarm_cont #(.NUM_ALARMS(NA), .IDX_W(2), .SNOOZE_MIN(SN), .RING_SECS(RS)) dut (
    .CLK(CLK), .RESETN(RESETN), .CUR_TIME(CUR_TIME), .SEC_TICK(SEC_TICK),
    .WR_EN(WR_EN), .WR_IDX(WR_IDX), .WR_TIME(WR_TIME), .WR_ON(WR_ON),
    .STOP(STOP), .SNOOZE(SNOOZE), .RD_IDX(RD_IDX), .RD_TIME(RD_TIME), .RD_ON(RD_ON),
    .WR_ERR(WR_ERR), .RINGING(RINGING), .RING_IDX(RING_IDX), .SNZ_ACTIVE(SNZ_ACTIVE),
    .PIEZO_EN(PIEZO_EN)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    int  cur;
    int  tm;
    bit  hit [NA];
    bit  started;
    int  wi;
    cur = cur_h * 3600 + cur_m * 60 + cur_s;
    wi  = int'(WR_IDX);
    if (RESETN) begin
      for (int i = 0; i < NA; i++) begin
        m_t[i] = 0; m_en[i] = 0; m_pend[i] = 0;
      end
      m_snz_v = 0; m_snz_t = 0; m_snz_i = 0;
      m_ring = 0; m_ridx = 0; m_secs = 0; m_err = 0;
      return;
    end
    m_err = 0;
    for (int i = 0; i < NA; i++) hit[i] = 0;
    if (SEC_TICK) begin
      for (int i = 0; i < NA; i++) if (m_en[i] && m_t[i] == cur) hit[i] = 1;
      if (m_snz_v && m_snz_t == cur) begin
        hit[m_snz_i] = 1;
        m_snz_v = 0;
      end
    end
    for (int i = 0; i < NA; i++) m_pend[i] = m_pend[i] | hit[i];
    if (!m_ring) begin
      started = 0;
      for (int i = 0; i < NA; i++) begin
        if (m_pend[i] && !started) begin
          started = 1; m_ring = 1; m_ridx = i; m_pend[i] = 0; m_secs = 0;
        end
      end
    end else if (STOP) begin
      m_ring = 0;
    end else if (SNOOZE) begin
      tm = (cur / 60 + SN) % 1440;
      m_snz_t = tm * 60 + cur % 60;
      m_snz_i = m_ridx;
      m_snz_v = 1;
      m_ring  = 0;
    end else if (SEC_TICK) begin
      m_secs++;
      if (m_secs == RS) m_ring = 0;
    end
    if (WR_EN) begin
      if (wi < NA && wr_h <= 23 && wr_m <= 59 && wr_s <= 59) begin
        m_t[wi]  = wr_h * 3600 + wr_m * 60 + wr_s;
        m_en[wi] = WR_ON;
        if (!WR_ON) begin
          m_pend[wi] = 0;
          if (m_snz_i == wi) m_snz_v = 0;
        end
      end else begin
        m_err = 1;
      end
    end
  endtask

  task automatic compare_all();
    int t;
    check("ringing", 32'(RINGING), 32'(m_ring));
    if (m_ring) check("ring_idx", 32'(RING_IDX), 32'(m_ridx));
    check("snz_active", 32'(SNZ_ACTIVE), 32'(m_snz_v));
    check("piezo_en", 32'(PIEZO_EN), 32'(m_ring && (m_secs % 2 == 0)));
    check("wr_err", 32'(WR_ERR), 32'(m_err));
    if (int'(RD_IDX) < NA) begin
      t = m_t[RD_IDX];
      check("rd_on", 32'(RD_ON), 32'(m_en[RD_IDX]));
      check("rd_time", 32'(RD_TIME), 32'(pk(t / 3600, (t / 60) % 60, t % 60)));
    end
  endtask

  task automatic step();
    @(posedge CLK);
    model_step();
    #1;
    compare_all();
    RESETN = 0; SEC_TICK = 0; WR_EN = 0; STOP = 0; SNOOZE = 0;
  endtask

  task automatic wr(int idx, int h, int m, int s, bit on);
    WR_EN = 1; WR_IDX = 2'(idx); wr_h = h; wr_m = m; wr_s = s; WR_ON = on;
    step();
  endtask

  task automatic tick(int h, int m, int s);
    SEC_TICK = 1; cur_h = h; cur_m = m; cur_s = s;
    step();
  endtask

  initial begin
    int t;
    int r;
    RESETN = 1; SEC_TICK = 0; WR_EN = 0; WR_IDX = 0; WR_ON = 0;
    STOP = 0; SNOOZE = 0; RD_IDX = 0;
    cur_h = 12; cur_m = 0; cur_s = 0; wr_h = 0; wr_m = 0; wr_s = 0;

    // Reset state
    step();
    check("rst_ringing", 32'(RINGING), 0);
    check("rst_snz", 32'(SNZ_ACTIVE), 0);
    check("rst_piezo", 32'(PIEZO_EN), 0);
    check("rst_wr_err", 32'(WR_ERR), 0);
    check("rst_rd_time", 32'(RD_TIME), 0);

    // Single alarm, one-cycle latency, read-back
    wr(1, 7, 0, 0, 1);
    RD_IDX = 1;
    tick(7, 0, 0);
    check("c1_ringing", 32'(RINGING), 1);
    check("c1_idx", 32'(RING_IDX), 1);
    check("c1_rd_time", 32'(RD_TIME), 32'(pk(7, 0, 0)));
    check("c1_rd_on", 32'(RD_ON), 1);
    check("c1_piezo", 32'(PIEZO_EN), 1);
    STOP = 1; step();
    check("c1_stop", 32'(RINGING), 0);

    // Coincident hits ring lowest first, then the queued one after one idle cycle
    wr(0, 6, 30, 0, 1);
    wr(2, 6, 30, 0, 1);
    tick(6, 30, 0);
    check("q_first_idx", 32'(RING_IDX), 0);
    STOP = 1; step();
    check("q_gap", 32'(RINGING), 0);
    step();
    check("q_second_ring", 32'(RINGING), 1);
    check("q_second_idx", 32'(RING_IDX), 2);
    STOP = 1; step();
    step();
    check("q_drained", 32'(RINGING), 0);

    // Snooze across midnight
    RD_IDX = 2;
    wr(2, 23, 58, 10, 1);
    tick(23, 58, 10);
    check("snz_ring", 32'(RING_IDX), 2);
    SNOOZE = 1; step();
    check("snz_set", 32'(SNZ_ACTIVE), 1);
    check("snz_idle", 32'(RINGING), 0);
    tick(0, 3, 10);
    check("snz_rering", 32'(RINGING), 1);
    check("snz_rering_idx", 32'(RING_IDX), 2);
    check("snz_cleared", 32'(SNZ_ACTIVE), 0);
    STOP = 1; step();

    // Ring timeout with beep gate
    tick(23, 58, 10);
    for (int k = 1; k <= RS; k++) begin
      tick(12, 0, 0);
      if (k == 1) check("gate_odd", 32'(PIEZO_EN), 0);
      if (k == 2) check("gate_even", 32'(PIEZO_EN), 1);
      if (k == RS - 1) check("to_still_ring", 32'(RINGING), 1);
    end
    check("to_stopped", 32'(RINGING), 0);
    tick(23, 58, 10);
    STOP = 1; SNOOZE = 1; step();
    check("stop_over_snz_ring", 32'(RINGING), 0);
    check("stop_over_snz_snz", 32'(SNZ_ACTIVE), 0);

    // Rejected writes
    RD_IDX = 0;
    wr(0, 24, 0, 0, 1);
    check("err_hour", 32'(WR_ERR), 1);
    check("err_hour_rd", 32'(RD_TIME), 32'(pk(6, 30, 0)));
    step();
    check("err_clear", 32'(WR_ERR), 0);
    wr(3, 6, 0, 0, 1);
    check("err_idx", 32'(WR_ERR), 1);
    wr(0, 12, 60, 0, 1);
    check("err_min", 32'(WR_ERR), 1);
    check("err_min_rd", 32'(RD_TIME), 32'(pk(6, 30, 0)));

    // Disabling a channel drops its pending hit and snooze
    wr(0, 7, 0, 0, 1);
    tick(7, 0, 0);
    STOP = 1; step();
    step();
    check("dis_ring1", 32'(RING_IDX), 1);
    SNOOZE = 1; step();
    tick(7, 0, 0);
    wr(1, 7, 0, 0, 0);
    check("dis_snz_drop", 32'(SNZ_ACTIVE), 0);
    check("dis_keeps_ring", 32'(RINGING), 1);
    STOP = 1; step();
    step();
    check("dis_pend_drop", 32'(RINGING), 0);
    tick(7, 5, 0);
    check("dis_no_snz_ring", 32'(RINGING), 0);

    // Reset mid-ring with queue and snooze live
    wr(1, 7, 0, 0, 1);
    tick(7, 0, 0);
    SNOOZE = 1; step();
    step();
    tick(7, 0, 0);
    RESETN = 1; step();
    check("mr_ringing", 32'(RINGING), 0);
    check("mr_idx", 32'(RING_IDX), 0);
    check("mr_snz", 32'(SNZ_ACTIVE), 0);
    check("mr_piezo", 32'(PIEZO_EN), 0);
    tick(7, 5, 0);
    check("mr_no_snz", 32'(RINGING), 0);
    tick(7, 0, 0);
    check("mr_no_alarm", 32'(RINGING), 0);

    // Randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      RESETN = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 2) == 0) begin
        SEC_TICK = 1;
        t = pool[$urandom_range(0, 5)];
        cur_h = t / 3600; cur_m = (t / 60) % 60; cur_s = t % 60;
      end
      STOP   = ($urandom_range(0, 19) == 0);
      SNOOZE = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 7) == 0) begin
        WR_EN  = 1;
        WR_IDX = 2'($urandom_range(0, 3));
        t = pool[$urandom_range(0, 5)];
        wr_h = t / 3600; wr_m = (t / 60) % 60; wr_s = t % 60;
        r = $urandom_range(0, 9);
        if (r == 0) wr_h = 24;
        if (r == 1) wr_m = 60;
        if (r == 2) wr_s = 60;
        WR_ON = ($urandom_range(0, 3) != 0);
      end
      RD_IDX = 2'($urandom_range(0, 2));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
